key_command_parser: RTL and testbench

- Assembles a Battleship shot command from keyboard bytes: letter key (row A–J), digit key (column), then Enter.
- Sits between the PS/2 receiver and `THE_GREAT_DECIDER`.
- Decodes set-2 make/break/extended sequences and supports Backspace/Esc editing.
- Presents a completed `{letter, number}` pair to the decider with a valid/ready handshake.

---
 rtl/battleship_pkg.sv | 53 +++++
 rtl/key_command_parser_if.sv | 23 ++
 rtl/key_command_parser_scan_decode.sv | 41 ++++
 rtl/key_command_parser.sv | 121 ++++++++++++
 tb/tb_key_command_parser.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/battleship_pkg.sv
// Shared Battleship definitions: PS/2 set-2 scan codes, entry stages and key classes.
package battleship_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned IDX_W  = 4;

  // Letter keys A..J
  localparam logic [CODE_W-1:0] SC_A = 8'h1C;
  localparam logic [CODE_W-1:0] SC_B = 8'h32;
  localparam logic [CODE_W-1:0] SC_C = 8'h21;
  localparam logic [CODE_W-1:0] SC_D = 8'h23;
  localparam logic [CODE_W-1:0] SC_E = 8'h24;
  localparam logic [CODE_W-1:0] SC_F = 8'h2B;
  localparam logic [CODE_W-1:0] SC_G = 8'h34;
  localparam logic [CODE_W-1:0] SC_H = 8'h33;
  localparam logic [CODE_W-1:0] SC_I = 8'h43;
  localparam logic [CODE_W-1:0] SC_J = 8'h3B;

  // Digit keys; '1' is column 0, '0' is column 9
  localparam logic [CODE_W-1:0] SC_1 = 8'h16;
  localparam logic [CODE_W-1:0] SC_2 = 8'h1E;
  localparam logic [CODE_W-1:0] SC_3 = 8'h26;
  localparam logic [CODE_W-1:0] SC_4 = 8'h25;
  localparam logic [CODE_W-1:0] SC_5 = 8'h2E;
  localparam logic [CODE_W-1:0] SC_6 = 8'h36;
  localparam logic [CODE_W-1:0] SC_7 = 8'h3D;
  localparam logic [CODE_W-1:0] SC_8 = 8'h3E;
  localparam logic [CODE_W-1:0] SC_9 = 8'h46;
  localparam logic [CODE_W-1:0] SC_0 = 8'h45;

  localparam logic [CODE_W-1:0] SC_ENTER = 8'h5A;
  localparam logic [CODE_W-1:0] SC_BKSP  = 8'h66;
  localparam logic [CODE_W-1:0] SC_ESC   = 8'h76;
  localparam logic [CODE_W-1:0] SC_BREAK = 8'hF0;
  localparam logic [CODE_W-1:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    S_LETTER = 2'd0,
    S_NUMBER = 2'd1,
    S_ENTER  = 2'd2,
    S_HOLD   = 2'd3
  } stage_e;

  typedef enum logic [2:0] {
    KC_LETTER  = 3'd0,
    KC_DIGIT   = 3'd1,
    KC_ENTER   = 3'd2,
    KC_BKSP    = 3'd3,
    KC_ESC     = 3'd4,
    KC_UNKNOWN = 3'd5
  } key_class_e;

endpackage

// File: rtl/key_command_parser_if.sv
// Keyboard-byte input and shot-command output bundle of the key command parser.
interface key_command_parser_if;
  logic [8:0] keyDataOut;
  logic       key_strobe;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [3:0] letter;
  logic [3:0] number;
  logic [1:0] entry_stage;
  logic       key_err;

  // master: the parser (consumes bytes, produces commands)
  modport master (
    input  keyDataOut, key_strobe, cmd_ready,
    output cmd_valid, letter, number, entry_stage, key_err
  );

  // slave: keyboard receiver plus decider side
  modport slave (
    output keyDataOut, key_strobe, cmd_ready,
    input  cmd_valid, letter, number, entry_stage, key_err
  );
endinterface

// File: rtl/key_command_parser_scan_decode.sv
// Combinational classification of a set-2 make code into key class and row/column index.
module scan_decode
  import battleship_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output key_class_e        key_class_c,
  output logic [IDX_W-1:0]  idx_c
);

  always_comb begin
    key_class_c = KC_UNKNOWN;
    idx_c       = '0;
    case (code)
      SC_A: begin key_class_c = KC_LETTER; idx_c = IDX_W'(0); end
      SC_B: begin key_class_c = KC_LETTER; idx_c = IDX_W'(1); end
      SC_C: begin key_class_c = KC_LETTER; idx_c = IDX_W'(2); end
      SC_D: begin key_class_c = KC_LETTER; idx_c = IDX_W'(3); end
      SC_E: begin key_class_c = KC_LETTER; idx_c = IDX_W'(4); end
      SC_F: begin key_class_c = KC_LETTER; idx_c = IDX_W'(5); end
      SC_G: begin key_class_c = KC_LETTER; idx_c = IDX_W'(6); end
      SC_H: begin key_class_c = KC_LETTER; idx_c = IDX_W'(7); end
      SC_I: begin key_class_c = KC_LETTER; idx_c = IDX_W'(8); end
      SC_J: begin key_class_c = KC_LETTER; idx_c = IDX_W'(9); end
      SC_1: begin key_class_c = KC_DIGIT;  idx_c = IDX_W'(0); end
      SC_2: begin key_class_c = KC_DIGIT;  idx_c = IDX_W'(1); end
      SC_3: begin key_class_c = KC_DIGIT;  idx_c = IDX_W'(2); end
      SC_4: begin key_class_c = KC_DIGIT;  idx_c = IDX_W'(3); end
      SC_5: begin key_class_c = KC_DIGIT;  idx_c = IDX_W'(4); end
      SC_6: begin key_class_c = KC_DIGIT;  idx_c = IDX_W'(5); end
      SC_7: begin key_class_c = KC_DIGIT;  idx_c = IDX_W'(6); end
      SC_8: begin key_class_c = KC_DIGIT;  idx_c = IDX_W'(7); end
      SC_9: begin key_class_c = KC_DIGIT;  idx_c = IDX_W'(8); end
      SC_0: begin key_class_c = KC_DIGIT;  idx_c = IDX_W'(9); end
      SC_ENTER: key_class_c = KC_ENTER;
      SC_BKSP:  key_class_c = KC_BKSP;
      SC_ESC:   key_class_c = KC_ESC;
      default:  key_class_c = KC_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/key_command_parser.sv
// Builds a {letter, number} shot command from PS/2 bytes with break/extended prefix
// filtering, Backspace/Esc editing and a valid/ready hand-off to the decider.
module key_command_parser
  import battleship_pkg::*;
(
  input  logic               clock27,
  input  logic               reset_n,
  key_command_parser_if.master bus
);

  logic [CODE_W-1:0] code_c;
  key_class_e        dec_class_c;
  logic [IDX_W-1:0]  dec_idx_c;
  logic              good_byte_c;
  logic              make_c;

  stage_e           state;
  logic             brk;
  logic             ext;
  logic             cmd_valid;
  logic [IDX_W-1:0] letter;
  logic [IDX_W-1:0] number;
  logic             key_err;

  assign code_c = bus.keyDataOut[CODE_W-1:0];

  scan_decode u_scan_decode (
    .code        (code_c),
    .key_class_c (dec_class_c),
    .idx_c       (dec_idx_c)
  );

  // A make code survives only outside a release; after E0 only keypad Enter counts
  always_comb begin
    good_byte_c = bus.key_strobe && !bus.keyDataOut[8];
    make_c      = 1'b0;
    if (good_byte_c && (code_c != SC_BREAK) && (code_c != SC_EXT) && !brk) begin
      make_c = ext ? (code_c == SC_ENTER) : 1'b1;
    end
  end

  always_ff @(posedge clock27 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_LETTER;
      brk       <= 1'b0;
      ext       <= 1'b0;
      cmd_valid <= 1'b0;
      letter    <= '0;
      number    <= '0;
      key_err   <= 1'b0;
    end else begin
      key_err <= 1'b0;

      if (good_byte_c) begin
        if (code_c == SC_BREAK) begin
          brk <= 1'b1;
        end else if (code_c == SC_EXT) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end

      case (state)
        S_LETTER: begin
          if (make_c) begin
            case (dec_class_c)
              KC_LETTER: begin
                letter <= dec_idx_c;
                state  <= S_NUMBER;
              end
              KC_BKSP, KC_ESC: ;
              default: key_err <= 1'b1;
            endcase
          end
        end
        S_NUMBER: begin
          if (make_c) begin
            case (dec_class_c)
              KC_DIGIT: begin
                number <= dec_idx_c;
                state  <= S_ENTER;
              end
              KC_BKSP, KC_ESC: state <= S_LETTER;
              default: key_err <= 1'b1;
            endcase
          end
        end
        S_ENTER: begin
          if (make_c) begin
            case (dec_class_c)
              KC_ENTER: begin
                state     <= S_HOLD;
                cmd_valid <= 1'b1;
              end
              KC_BKSP: state <= S_NUMBER;
              KC_ESC:  state <= S_LETTER;
              default: key_err <= 1'b1;
            endcase
          end
        end
        S_HOLD: begin
          // Keys are dropped while the command waits for the decider
          if (bus.cmd_ready) begin
            state     <= S_LETTER;
            cmd_valid <= 1'b0;
          end
        end
        default: state <= S_LETTER;
      endcase
    end
  end

  assign bus.cmd_valid   = cmd_valid;
  assign bus.letter      = letter;
  assign bus.number      = number;
  assign bus.entry_stage = state;
  assign bus.key_err     = key_err;

endmodule

// File: tb/tb_key_command_parser.sv
// Directed scoreboard bench for key_command_parser: expected outputs are queued with each
// driven cycle and popped for comparison once the DUT has reacted.
module tb_key_command_parser;

  typedef struct {
    string      tag;
    logic [1:0] stage;
    logic [3:0] letter;
    logic [3:0] number;
    logic       valid;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  key_command_parser_if bus ();

  key_command_parser dut (
    .clock27 (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [1:0] st, input logic [3:0] l,
                      input logic [3:0] n, input logic v, input logic e);
    exp_t x;
    x.tag = tag; x.stage = st; x.letter = l; x.number = n; x.valid = v; x.err = e;
    sb.push_back(x);
  endtask

  task automatic pop_compare();
    exp_t x;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      x = sb.pop_front();
      n_cmp++;
      assert (bus.entry_stage === x.stage) else begin
        n_bad++;
        $error("FAIL %s.entry_stage observed=%0d expected=%0d", x.tag, bus.entry_stage, x.stage);
      end
      n_cmp++;
      assert (bus.letter === x.letter) else begin
        n_bad++;
        $error("FAIL %s.letter observed=%0d expected=%0d", x.tag, bus.letter, x.letter);
      end
      n_cmp++;
      assert (bus.number === x.number) else begin
        n_bad++;
        $error("FAIL %s.number observed=%0d expected=%0d", x.tag, bus.number, x.number);
      end
      n_cmp++;
      assert (bus.cmd_valid === x.valid) else begin
        n_bad++;
        $error("FAIL %s.cmd_valid observed=%0b expected=%0b", x.tag, bus.cmd_valid, x.valid);
      end
      n_cmp++;
      assert (bus.key_err === x.err) else begin
        n_bad++;
        $error("FAIL %s.key_err observed=%0b expected=%0b", x.tag, bus.key_err, x.err);
      end
    end
  endtask

  // One clock cycle with optional strobe/ready; outputs checked 1 time unit after the edge
  task automatic step(input string tag, input logic stb, input logic [8:0] data,
                      input logic rdy, input logic [1:0] st, input logic [3:0] l,
                      input logic [3:0] n, input logic v, input logic e);
    @(negedge clk);
    bus.key_strobe = stb;
    bus.keyDataOut = data;
    bus.cmd_ready  = rdy;
    push(tag, st, l, n, v, e);
    @(posedge clk);
    #1;
    bus.key_strobe = 1'b0;
    bus.cmd_ready  = 1'b0;
    pop_compare();
  endtask

  task automatic key(input string tag, input logic [8:0] data, input logic [1:0] st,
                     input logic [3:0] l, input logic [3:0] n, input logic v, input logic e);
    step(tag, 1'b1, data, 1'b0, st, l, n, v, e);
  endtask

  task automatic idle(input string tag, input logic rdy, input logic [1:0] st,
                      input logic [3:0] l, input logic [3:0] n, input logic v, input logic e);
    step(tag, 1'b0, 9'h000, rdy, st, l, n, v, e);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.keyDataOut = '0;
    bus.key_strobe = 1'b0;
    bus.cmd_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    push("reset", 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    pop_compare();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic command E8 with break codes interleaved
    key("e_make",   9'h024, 2'd1, 4'd4, 4'd0, 1'b0, 1'b0);
    key("e_f0",     9'h0F0, 2'd1, 4'd4, 4'd0, 1'b0, 1'b0);
    key("e_brk",    9'h024, 2'd1, 4'd4, 4'd0, 1'b0, 1'b0);
    key("d8_make",  9'h03E, 2'd2, 4'd4, 4'd7, 1'b0, 1'b0);
    key("d8_f0",    9'h0F0, 2'd2, 4'd4, 4'd7, 1'b0, 1'b0);
    key("d8_brk",   9'h03E, 2'd2, 4'd4, 4'd7, 1'b0, 1'b0);
    key("enter",    9'h05A, 2'd3, 4'd4, 4'd7, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) idle("hold20", 1'b0, 2'd3, 4'd4, 4'd7, 1'b1, 1'b0);
    idle("handshake", 1'b1, 2'd0, 4'd4, 4'd7, 1'b0, 1'b0);
    idle("ready_idle", 1'b1, 2'd0, 4'd4, 4'd7, 1'b0, 1'b0);

    // Editing: A0, backspace, 1, keypad Enter
    key("ed_a",     9'h01C, 2'd1, 4'd0, 4'd7, 1'b0, 1'b0);
    key("ed_0",     9'h045, 2'd2, 4'd0, 4'd9, 1'b0, 1'b0);
    key("ed_bksp",  9'h066, 2'd1, 4'd0, 4'd9, 1'b0, 1'b0);
    key("ed_1",     9'h016, 2'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    key("ed_e0",    9'h0E0, 2'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    key("ed_kpent", 9'h05A, 2'd3, 4'd0, 4'd0, 1'b1, 1'b0);
    idle("ed_hs",   1'b1, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    key("esc_a",    9'h01C, 2'd1, 4'd0, 4'd0, 1'b0, 1'b0);
    key("esc",      9'h076, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    key("esc_s0",   9'h076, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Error handling
    key("err_dig",  9'h016, 2'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    idle("err_end", 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    key("h_make",   9'h033, 2'd1, 4'd7, 4'd0, 1'b0, 1'b0);
    key("err_let",  9'h01C, 2'd1, 4'd7, 4'd0, 1'b0, 1'b1);
    key("d5_make",  9'h02E, 2'd2, 4'd7, 4'd4, 1'b0, 1'b0);
    key("err_unk",  9'h01D, 2'd2, 4'd7, 4'd4, 1'b0, 1'b1);
    idle("unk_end", 1'b0, 2'd2, 4'd7, 4'd4, 1'b0, 1'b0);
    key("arr_e0",   9'h0E0, 2'd2, 4'd7, 4'd4, 1'b0, 1'b0);
    key("arr_75",   9'h075, 2'd2, 4'd7, 4'd4, 1'b0, 1'b0);
    idle("arr_end", 1'b0, 2'd2, 4'd7, 4'd4, 1'b0, 1'b0);

    // Byte filtering: bad-parity byte keeps the pending break, break-Enter is no command
    key("flt_f0",   9'h0F0, 2'd2, 4'd7, 4'd4, 1'b0, 1'b0);
    key("flt_bad",  9'h13B, 2'd2, 4'd7, 4'd4, 1'b0, 1'b0);
    key("flt_3b",   9'h03B, 2'd2, 4'd7, 4'd4, 1'b0, 1'b0);
    key("brk_f0",   9'h0F0, 2'd2, 4'd7, 4'd4, 1'b0, 1'b0);
    key("brk_ent",  9'h05A, 2'd2, 4'd7, 4'd4, 1'b0, 1'b0);
    idle("brk_end", 1'b0, 2'd2, 4'd7, 4'd4, 1'b0, 1'b0);

    // Hold: keys ignored, strobe coinciding with the handshake is dropped
    key("hold_ent", 9'h05A, 2'd3, 4'd7, 4'd4, 1'b1, 1'b0);
    key("hold_unk", 9'h01D, 2'd3, 4'd7, 4'd4, 1'b1, 1'b0);
    step("hold_hs", 1'b1, 9'h032, 1'b1, 2'd0, 4'd7, 4'd4, 1'b0, 1'b0);
    idle("hs_after", 1'b0, 2'd0, 4'd7, 4'd4, 1'b0, 1'b0);

    // Asynchronous reset mid-command, then a full command
    key("rs_j",     9'h03B, 2'd1, 4'd9, 4'd4, 1'b0, 1'b0);
    key("rs_9",     9'h046, 2'd2, 4'd9, 4'd8, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_rst", 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    pop_compare();
    @(negedge clk);
    rst_n = 1'b1;
    key("pr_c",     9'h021, 2'd1, 4'd2, 4'd0, 1'b0, 1'b0);
    key("pr_4",     9'h025, 2'd2, 4'd2, 4'd3, 1'b0, 1'b0);
    key("pr_ent",   9'h05A, 2'd3, 4'd2, 4'd3, 1'b1, 1'b0);
    idle("pr_hs",   1'b1, 2'd0, 4'd2, 4'd3, 1'b0, 1'b0);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
